// File: rtl/door_pkg.sv
// Shared door command definitions: state encoding common to the control FSM
// and the actuator, plus the motor direction levels.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED    = 2'b00,
    OPENING   = 2'b01,
    OPEN_HOLD = 2'b10,
    CLOSING   = 2'b11
  } door_state_t;

  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

endpackage

// File: rtl/door_actuator_if.sv
// Door command interface between the control FSM (master) and the actuator
// (slave): command pulses out, timeout pulse and end-stop status back.
interface door_actuator_if;
  import door_pkg::*;

  logic cmd_open;
  logic cmd_close;
  logic timeout;
  logic fully_open;
  logic fully_closed;

  modport master (
    output cmd_open,
    output cmd_close,
    input  timeout,
    input  fully_open,
    input  fully_closed
  );

  modport slave (
    input  cmd_open,
    input  cmd_close,
    output timeout,
    output fully_open,
    output fully_closed
  );

endinterface

// File: rtl/door_actuator_hold_timer.sv
// Open-hold interval timer: counts idle cycles while enabled and emits a
// single-cycle timeout pulse once per expiry, re-armed only by a restart.
module door_hold_timer
  import door_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_expired;
  logic             r_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
      r_expired  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (!i_enable || i_restart) begin
        r_hold_cnt <= '0;
        r_expired  <= 1'b0;
      end else if (!r_expired) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
        // Expiry latches so the pulse fires once until a restart.
        if (r_hold_cnt == L_HOLD_LAST) begin
          r_timeout <= 1'b1;
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/door_actuator.sv
// Door actuator responder: sequences motor enable/direction from open/close
// command pulses, tracks travel position and reports hold timeout/end-stops.
module door_actuator
  import door_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  door_actuator_if.slave   cmd_if,
  input  logic             i_sensor,
  output logic             o_motor_en,
  output logic             o_motor_dir,
  output logic [CNT_W-1:0] o_door_pos
);

  localparam logic [CNT_W-1:0] L_TRAVEL    = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] L_TRAVEL_M1 = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

  door_state_t      r_state;
  door_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_door_pos;
  logic [CNT_W-1:0] w_door_pos_nxt;
  logic             w_open_req;
  logic             w_close_req;
  logic             w_timeout_raw;

  assign w_open_req  = cmd_if.cmd_open;
  assign w_close_req = cmd_if.cmd_close && !cmd_if.cmd_open;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= CLOSED;
      r_door_pos <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_door_pos <= w_door_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_door_pos_nxt = r_door_pos;
    case (r_state)
      CLOSED: begin
        if (w_open_req) w_state_nxt = OPENING;
      end
      OPENING: begin
        if (w_close_req) begin
          w_state_nxt = CLOSING;
        end else if (r_door_pos == L_TRAVEL) begin
          // Reversal right at the top of travel: settle without stepping.
          w_state_nxt = OPEN_HOLD;
        end else begin
          w_door_pos_nxt = r_door_pos + 1'b1;
          if (r_door_pos == L_TRAVEL_M1) w_state_nxt = OPEN_HOLD;
        end
      end
      OPEN_HOLD: begin
        if (w_close_req) w_state_nxt = CLOSING;
      end
      CLOSING: begin
        // Safety reversal outranks the closing step.
        if (i_sensor || w_open_req) begin
          w_state_nxt = OPENING;
        end else if (r_door_pos == '0) begin
          w_state_nxt = CLOSED;
        end else begin
          w_door_pos_nxt = r_door_pos - 1'b1;
          if (r_door_pos == L_ONE) w_state_nxt = CLOSED;
        end
      end
      default: begin
        w_state_nxt    = CLOSED;
        w_door_pos_nxt = '0;
      end
    endcase
  end

  door_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_enable  (r_state == OPEN_HOLD),
    .i_restart (i_sensor || cmd_if.cmd_open),
    .o_timeout (w_timeout_raw)
  );

  assign o_motor_en          = (r_state == OPENING) || (r_state == CLOSING);
  assign o_motor_dir         = (r_state == OPENING) ? DIR_OPEN : DIR_CLOSE;
  assign o_door_pos          = r_door_pos;
  assign cmd_if.fully_open   = (r_state == OPEN_HOLD);
  assign cmd_if.fully_closed = (r_state == CLOSED);
  // A pulse raised on the edge that leaves OPEN_HOLD is dropped.
  assign cmd_if.timeout      = w_timeout_raw && (r_state == OPEN_HOLD);

endmodule
